pipe_stage_chain: RTL
=====================

# pipe_stage_chain

Parametrised pipeline-register chain replacing the fixed per-boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It has configurable payload width and stage count, a valid bit per stage, per-stage stall with automatic bubble insertion, per-stage flush, an occupancy count and two saturating performance counters. Hazard and branch logic drive `stall`/`flush`. The datapath taps any stage through `stage_data`.

## Interface
- `WIDTH`, 32: payload bits per stage.
- `STAGES`, 4: number of register stages (>=2).
- `OCC_W`, $clog2(STAGES+1): occupancy width.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` holds a valid instruction.
- `in_data`  in  WIDTH: payload entering stage 0.
- `in_ready`  out  1: stage 0 accepts this cycle.
- `stall`  in  STAGES: `stall[k]` freezes stage k and all stages upstream of it.
- `flush`  in  STAGES: `flush[k]` kills whatever would be in stage k after the edge.
- `stage_valid`  out  STAGES: valid bit of each stage.
- `stage_data`  out  STAGES*WIDTH: stage k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  1: equals `stage_valid[STAGES-1]`.
- `out_data`  out  WIDTH: payload of the last stage.
- `occupancy`  out  OCC_W: popcount of `stage_valid`.
- `stall_cycles`  out  16: saturating count of cycles with any stall bit set.
- `retired`  out  16: saturating count of instructions leaving the last stage.

## Operation
- `hold[k] = |stall[STAGES-1:k]`. A stall at k holds stages 0..k.
- Next-state of stage k at each rising edge, in priority order:
  1. `flush[k]`: valid←0, data←0.
  2. `hold[k]`: stage keeps its contents.
  3. k>0, `hold[k-1]`=1 and `hold[k]`=0: bubble inserted, valid←0, data←0.
  4. k>0 otherwise: valid/data ← stage k-1.
  5. k=0: valid←`in_valid`, data←`in_valid` ? `in_data` : 0.
- `in_ready = ~hold[0]` (equivalently `~|stall`).
- `in_data` is consumed only when `in_valid & in_ready` and `flush[0]`=0.
- Retire event: `out_valid & ~stall[STAGES-1]`. The last stage drains every unstalled cycle. A downstream consumer must take `out_data` in that cycle.
- `flush[STAGES-1]` together with `stall[STAGES-1]` clears the held instruction with no retire event.
- `stall_cycles` increments when `|stall`. `retired` increments on a retire event. Both saturate at 0xFFFF and never wrap.
- `occupancy` is combinational from the stage valid registers.
- Data of invalid stages is always 0. This makes bubbles equivalent to the all-zero NOP encoding.

## Timing
- Reset (`rst`=0), asynchronous and immediate:
  - all `stage_valid`=0 and all `stage_data`=0;
  - `out_valid`=0 and `out_data`=0;
  - `occupancy`=0, `stall_cycles`=0, `retired`=0;
  - `in_ready` follows `stall` combinationally.
- Reset asserted mid-stream discards all in-flight stages. The first accept after deassertion occurs at the first rising edge with `rst`=1.
- Latency with no stalls: data accepted at edge N appears in stage k after edge N+k. It is visible on `out_data` after edge N+STAGES-1, i.e. in the STAGES-th cycle after acceptance.
- Throughput: one instruction per cycle.
- A stall at stage k costs exactly one bubble per stalled cycle in stage k+1. The bubble propagates downstream.
- Simultaneous `stall[k]` and `flush[k]`: flush wins for stage k. Stages 0..k-1 still hold.
- Counter updates are registered and visible the cycle after the event edge.

## Test plan
- Reset mid-stream (STAGES=4, three valid stages, both counters >0), drive `rst`=0 between edges -> all valid 0, data 0, `occupancy`=0, counters 0 before the next edge.
- Streaming: accept 0x11, 0x22, 0x33 on consecutive edges N..N+2, no stalls -> `out_data`=0x11 after edge N+3, 0x22 after N+4, 0x33 after N+5; `retired`=3 afterwards; `occupancy` peaks at 3.
- Stage 0=A, stage 1=B, `stall`=4'b0010 for 2 cycles -> A and B hold, `in_ready`=0, stage 2 receives two bubbles (valid 0, data 0), `stall_cycles` +2; release -> B enters stage 2 on the next edge.
- Stage 0 valid, `stall[0]`=1 and `flush[0]`=1 in the same cycle -> stage 0 valid 0, data 0; stage 1 gets a bubble; `in_data` not consumed.
- Stall and flush on the last stage: `stall[3]` for 3 cycles with the last stage valid -> whole chain frozen, `out_valid` held, `retired` unchanged; then `flush[3]` with `stall[3]` -> last stage cleared, `retired` unchanged.
- Saturation: hold `stall`!=0 for 70000 cycles -> `stall_cycles`=0xFFFF and stays there; it does not wrap.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Generic pipeline-register chain: per-stage valid, stall with bubble insertion,
// flush, occupancy and saturating stall/retire counters.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [OCC_W-1:0]          occupancy,
    output logic [15:0]               stall_cycles,
    output logic [15:0]               retired
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic              retire;

    // A stall anywhere downstream freezes this stage too.
    always_comb begin
        hold[STAGES-1] = stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            hold[k] = hold[k+1] | stall[k];
        end
    end

    assign in_ready = ~hold[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q[0] <= 1'b0;
            data_q[0]  <= '0;
        end else if (flush[0]) begin
            valid_q[0] <= 1'b0;
            data_q[0]  <= '0;
        end else if (!hold[0]) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q[g] <= 1'b0;
                data_q[g]  <= '0;
            end else if (flush[g]) begin
                valid_q[g] <= 1'b0;
                data_q[g]  <= '0;
            end else if (hold[g]) begin
                valid_q[g] <= valid_q[g];
                data_q[g]  <= data_q[g];
            end else if (hold[g-1]) begin
                valid_q[g] <= 1'b0;
                data_q[g]  <= '0;
            end else begin
                valid_q[g] <= valid_q[g-1];
                data_q[g]  <= data_q[g-1];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign retire      = valid_q[STAGES-1] & ~stall[STAGES-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + {{(OCC_W-1){1'b0}}, valid_q[k]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            retired      <= '0;
        end else begin
            if ((|stall) && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (retire && (retired != 16'hFFFF)) begin
                retired <= retired + 16'd1;
            end
        end
    end

endmodule
